load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 42 ++++
 rtl/load_store_unit_aligner.sv | 30 +++
 rtl/load_store_unit.sv | 116 +++++++++++
 tb/tb_load_store_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared load/store definitions: FSM states, load split options, store masks.
// The access legality check lives here so the decoder and the LSU agree on it.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    IDLE          = 2'd0,
    REQUEST       = 2'd1,
    WAIT_RESPONSE = 2'd2,
    DONE          = 2'd3
  } lsu_state_e;

  localparam logic [2:0] SPLIT_LW  = 3'b000;
  localparam logic [2:0] SPLIT_LH  = 3'b001;
  localparam logic [2:0] SPLIT_LHU = 3'b010;
  localparam logic [2:0] SPLIT_LB  = 3'b011;
  localparam logic [2:0] SPLIT_LBU = 3'b100;

  localparam logic [3:0] MASK_LOAD = 4'b0000;
  localparam logic [3:0] MASK_SB   = 4'b0001;
  localparam logic [3:0] MASK_SH   = 4'b0011;
  localparam logic [3:0] MASK_SW   = 4'b1111;

  // Stores are sized by their mask, loads by their split option.
  function automatic logic access_is_faulty(input logic [1:0] offset,
                                            input logic [3:0] mask,
                                            input logic [2:0] option);
    logic bad_mask;
    logic bad_option;
    logic misaligned;
    bad_mask   = !(mask == MASK_LOAD || mask == MASK_SB || mask == MASK_SH || mask == MASK_SW);
    bad_option = (option > SPLIT_LBU);
    if (mask == MASK_LOAD) begin
      misaligned = ((option == SPLIT_LW) && (offset != 2'b00)) ||
                   (((option == SPLIT_LH) || (option == SPLIT_LHU)) && offset[0]);
    end else begin
      misaligned = ((mask == MASK_SW) && (offset != 2'b00)) ||
                   ((mask == MASK_SH) && offset[0]);
    end
    return bad_mask || bad_option || misaligned;
  endfunction

endpackage

// File: rtl/load_store_unit_aligner.sv
// Picks the addressed byte/half out of a read word and sign- or zero-extends it.
// Purely combinational.
module load_data_aligner
  import load_store_unit_pkg::*;
(
  input  logic [31:0] read_word,
  input  logic [1:0]  byte_offset,
  input  logic [2:0]  split_option,
  output logic [31:0] aligned_data
);

  logic [31:0] shifted;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    shifted   = read_word >> {byte_offset, 3'b000};
    lane_byte = shifted[7:0];
    lane_half = byte_offset[1] ? read_word[31:16] : read_word[15:0];
    case (split_option)
      SPLIT_LW:  aligned_data = read_word;
      SPLIT_LH:  aligned_data = {{16{lane_half[15]}}, lane_half};
      SPLIT_LHU: aligned_data = {16'h0000, lane_half};
      SPLIT_LB:  aligned_data = {{24{lane_byte[7]}}, lane_byte};
      SPLIT_LBU: aligned_data = {24'h000000, lane_byte};
      default:   aligned_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit bridging the execute stage to a valid/ready bus.
// Illegal or misaligned accesses fault straight to DONE without touching the bus.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        request_valid,
  output logic        request_ready,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  input  logic [3:0]  memory_write_enable,
  input  logic [2:0]  memory_split_option,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic [31:0] bus_address,
  output logic        bus_write,
  output logic [3:0]  bus_byte_enable,
  output logic [31:0] bus_write_data,
  input  logic [31:0] bus_read_data,
  input  logic        bus_response_valid,
  output logic        response_valid,
  output logic [31:0] load_data,
  output logic        access_fault
);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        write_q, write_d;
  logic [2:0]  option_q, option_d;
  logic        fault_q, fault_d;
  logic [31:0] load_data_q, load_data_d;
  logic [31:0] aligned_data;
  logic        request_fault;

  load_data_aligner u_aligner (
    .read_word    (bus_read_data),
    .byte_offset  (addr_q[1:0]),
    .split_option (option_q),
    .aligned_data (aligned_data)
  );

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    be_d          = be_q;
    write_d       = write_q;
    option_d      = option_q;
    fault_d       = fault_q;
    load_data_d   = load_data_q;
    request_fault = access_is_faulty(address[1:0], memory_write_enable, memory_split_option);
    case (state_q)
      IDLE: begin
        if (request_valid) begin
          addr_d   = address;
          wdata_d  = store_data << {address[1:0], 3'b000};
          be_d     = memory_write_enable << address[1:0];
          write_d  = (memory_write_enable != MASK_LOAD);
          option_d = memory_split_option;
          fault_d  = request_fault;
          state_d  = request_fault ? DONE : REQUEST;
        end
      end
      REQUEST: begin
        if (bus_ready) state_d = write_q ? DONE : WAIT_RESPONSE;
      end
      WAIT_RESPONSE: begin
        if (bus_response_valid) begin
          load_data_d = aligned_data;
          state_d     = DONE;
        end
      end
      DONE: begin
        fault_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      write_q     <= 1'b0;
      option_q    <= '0;
      fault_q     <= 1'b0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      write_q     <= write_d;
      option_q    <= option_d;
      fault_q     <= fault_d;
      load_data_q <= load_data_d;
    end
  end

  assign request_ready   = (state_q == IDLE);
  assign bus_valid       = (state_q == REQUEST);
  assign bus_address     = {addr_q[31:2], 2'b00};
  assign bus_write       = write_q;
  assign bus_byte_enable = be_q;
  assign bus_write_data  = wdata_q;
  assign response_valid  = (state_q == DONE);
  assign access_fault    = (state_q == DONE) && fault_q;
  assign load_data       = load_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, faults, bus stalls and mid-access reset.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        request_valid = 1'b0;
  logic        request_ready;
  logic [31:0] address = '0;
  logic [31:0] store_data = '0;
  logic [3:0]  memory_write_enable = '0;
  logic [2:0]  memory_split_option = '0;
  logic        bus_valid;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_address;
  logic        bus_write;
  logic [3:0]  bus_byte_enable;
  logic [31:0] bus_write_data;
  logic [31:0] bus_read_data = '0;
  logic        bus_response_valid = 1'b0;
  logic        response_valid;
  logic [31:0] load_data;
  logic        access_fault;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clock = ~clock;

  load_store_unit dut (
    .clock               (clock),
    .reset               (reset),
    .request_valid       (request_valid),
    .request_ready       (request_ready),
    .address             (address),
    .store_data          (store_data),
    .memory_write_enable (memory_write_enable),
    .memory_split_option (memory_split_option),
    .bus_valid           (bus_valid),
    .bus_ready           (bus_ready),
    .bus_address         (bus_address),
    .bus_write           (bus_write),
    .bus_byte_enable     (bus_byte_enable),
    .bus_write_data      (bus_write_data),
    .bus_read_data       (bus_read_data),
    .bus_response_valid  (bus_response_valid),
    .response_valid      (response_valid),
    .load_data           (load_data),
    .access_fault        (access_fault)
  );

  // Presents one request for a single cycle; returns at the negedge after acceptance.
  task automatic issue(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m, input logic [2:0] o);
    @(negedge clock);
    request_valid       = 1'b1;
    address             = a;
    store_data          = d;
    memory_write_enable = m;
    memory_split_option = o;
    @(negedge clock);
    request_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    total_cnt++;
    if (request_ready !== 1'b1) $display("FAIL reset_request_ready got %b want 1", request_ready);
    else pass_cnt++;
    total_cnt++;
    if ({bus_valid, response_valid, access_fault, bus_write} !== 4'b0000)
      $display("FAIL reset_flags got %b want 0000", {bus_valid, response_valid, access_fault, bus_write});
    else pass_cnt++;
    total_cnt++;
    if ({bus_address, bus_write_data, load_data, bus_byte_enable} !== 100'd0)
      $display("FAIL reset_data addr %h wdata %h load %h be %b want all zero",
               bus_address, bus_write_data, load_data, bus_byte_enable);
    else pass_cnt++;
  endtask

  task automatic test_loads();
    logic [31:0] a_tab [0:4];
    logic [2:0]  o_tab [0:4];
    logic [31:0] r_tab [0:4];
    logic [31:0] e_tab [0:4];
    a_tab[0] = 32'h0000_1003; o_tab[0] = 3'b011; r_tab[0] = 32'h80FF_1234; e_tab[0] = 32'hFFFF_FF80;
    a_tab[1] = 32'h0000_2002; o_tab[1] = 3'b010; r_tab[1] = 32'hBEEF_0000; e_tab[1] = 32'h0000_BEEF;
    a_tab[2] = 32'h0000_2000; o_tab[2] = 3'b001; r_tab[2] = 32'h0000_8001; e_tab[2] = 32'hFFFF_8001;
    a_tab[3] = 32'h0000_1001; o_tab[3] = 3'b100; r_tab[3] = 32'h0000_F000; e_tab[3] = 32'h0000_00F0;
    a_tab[4] = 32'h0000_1004; o_tab[4] = 3'b000; r_tab[4] = 32'hDEAD_BEEF; e_tab[4] = 32'hDEAD_BEEF;
    bus_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      issue(a_tab[i], 32'h0, 4'b0000, o_tab[i]);
      total_cnt++;
      if ({bus_valid, bus_write, bus_byte_enable, bus_address} !== {1'b1, 1'b0, 4'b0000, a_tab[i][31:2], 2'b00})
        $display("FAIL load%0d_bus valid %b write %b be %b addr %h want 1 0 0000 %h", i,
                 bus_valid, bus_write, bus_byte_enable, bus_address, {a_tab[i][31:2], 2'b00});
      else pass_cnt++;
      @(negedge clock);
      bus_response_valid = 1'b1;
      bus_read_data      = r_tab[i];
      @(negedge clock);
      bus_response_valid = 1'b0;
      bus_read_data      = 32'h5555_5555;
      total_cnt++;
      if ({response_valid, access_fault, load_data} !== {1'b1, 1'b0, e_tab[i]})
        $display("FAIL load%0d_result resp %b fault %b data %h want 1 0 %h", i,
                 response_valid, access_fault, load_data, e_tab[i]);
      else pass_cnt++;
      @(negedge clock);
      total_cnt++;
      if ({response_valid, request_ready} !== 2'b01)
        $display("FAIL load%0d_pulse resp %b ready %b want 0 1", i, response_valid, request_ready);
      else pass_cnt++;
    end
  endtask

  task automatic test_store_sb();
    bus_ready = 1'b1;
    issue(32'h0000_3001, 32'h0000_00AB, 4'b0001, 3'b000);
    total_cnt++;
    if ({bus_valid, bus_write, bus_byte_enable, bus_address, bus_write_data} !==
        {1'b1, 1'b1, 4'b0010, 32'h0000_3000, 32'h0000_AB00})
      $display("FAIL sb_bus valid %b write %b be %b addr %h wdata %h want 1 1 0010 00003000 0000ab00",
               bus_valid, bus_write, bus_byte_enable, bus_address, bus_write_data);
    else pass_cnt++;
    total_cnt++;
    if (response_valid !== 1'b0) $display("FAIL sb_early_resp got %b want 0", response_valid);
    else pass_cnt++;
    @(negedge clock);
    total_cnt++;
    if ({response_valid, access_fault, bus_valid} !== 3'b100)
      $display("FAIL sb_resp resp %b fault %b bus_valid %b want 1 0 0", response_valid, access_fault, bus_valid);
    else pass_cnt++;
    total_cnt++;
    if (load_data !== 32'hDEAD_BEEF) $display("FAIL sb_load_data_kept got %h want deadbeef", load_data);
    else pass_cnt++;
    @(negedge clock);
  endtask

  task automatic test_faults();
    logic [31:0] a_tab [0:4];
    logic [3:0]  m_tab [0:4];
    logic [2:0]  o_tab [0:4];
    logic        seen_resp, seen_fault, seen_bus;
    a_tab[0] = 32'h0000_4002; m_tab[0] = 4'b1111; o_tab[0] = 3'b000;
    a_tab[1] = 32'h0000_4001; m_tab[1] = 4'b0011; o_tab[1] = 3'b000;
    a_tab[2] = 32'h0000_4000; m_tab[2] = 4'b0111; o_tab[2] = 3'b000;
    a_tab[3] = 32'h0000_4000; m_tab[3] = 4'b0000; o_tab[3] = 3'b101;
    a_tab[4] = 32'h0000_4003; m_tab[4] = 4'b0000; o_tab[4] = 3'b001;
    bus_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      issue(a_tab[i], 32'h1234_5678, m_tab[i], o_tab[i]);
      seen_resp = 1'b0; seen_fault = 1'b0; seen_bus = 1'b0;
      for (int c = 0; c < 2; c++) begin
        if (bus_valid) seen_bus = 1'b1;
        if (response_valid && !seen_resp) begin
          seen_resp  = 1'b1;
          seen_fault = access_fault;
        end
        @(negedge clock);
      end
      total_cnt++;
      if ({seen_resp, seen_fault, seen_bus} !== 3'b110)
        $display("FAIL fault%0d resp %b fault %b bus_valid_seen %b want 1 1 0", i, seen_resp, seen_fault, seen_bus);
      else pass_cnt++;
    end
    total_cnt++;
    if ({request_ready, load_data} !== {1'b1, 32'hDEAD_BEEF})
      $display("FAIL fault_after ready %b data %h want 1 deadbeef", request_ready, load_data);
    else pass_cnt++;
  endtask

  task automatic test_stray_response();
    bus_response_valid = 1'b1;
    bus_read_data      = 32'hCAFE_F00D;
    @(negedge clock);
    bus_response_valid = 1'b0;
    total_cnt++;
    if ({response_valid, load_data} !== {1'b0, 32'hDEAD_BEEF})
      $display("FAIL stray_resp resp %b data %h want 0 deadbeef", response_valid, load_data);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    bus_ready = 1'b0;
    issue(32'h0000_6002, 32'h0000_1234, 4'b0011, 3'b000);
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if ({bus_valid, request_ready, response_valid, bus_write, bus_byte_enable, bus_address, bus_write_data} !==
          {1'b1, 1'b0, 1'b0, 1'b1, 4'b1100, 32'h0000_6000, 32'h1234_0000})
        $display("FAIL stall%0d valid %b ready %b resp %b write %b be %b addr %h wdata %h want 1 0 0 1 1100 00006000 12340000",
                 i, bus_valid, request_ready, response_valid, bus_write, bus_byte_enable, bus_address, bus_write_data);
      else pass_cnt++;
      @(negedge clock);
    end
    bus_ready = 1'b1;
    @(negedge clock);
    total_cnt++;
    if ({response_valid, access_fault, bus_valid} !== 3'b100)
      $display("FAIL stall_resp resp %b fault %b bus_valid %b want 1 0 0", response_valid, access_fault, bus_valid);
    else pass_cnt++;
    @(negedge clock);
  endtask

  task automatic test_reset_mid_access();
    logic seen_resp;
    bus_ready = 1'b1;
    issue(32'h0000_7000, 32'h0, 4'b0000, 3'b000);
    @(negedge clock);
    total_cnt++;
    if ({bus_valid, response_valid, request_ready} !== 3'b000)
      $display("FAIL mid_wait valid %b resp %b ready %b want 0 0 0", bus_valid, response_valid, request_ready);
    else pass_cnt++;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    bus_response_valid = 1'b1;
    bus_read_data      = 32'h7777_7777;
    seen_resp = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      bus_response_valid = 1'b0;
      if (response_valid) seen_resp = 1'b1;
    end
    total_cnt++;
    if (seen_resp !== 1'b0) $display("FAIL mid_reset_resp got %b want 0", seen_resp);
    else pass_cnt++;
    total_cnt++;
    if ({request_ready, bus_valid, access_fault, bus_write, bus_byte_enable, bus_address, bus_write_data, load_data} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h0})
      $display("FAIL mid_reset_outputs ready %b valid %b fault %b write %b be %b addr %h wdata %h load %h want 1 0 0 0 0000 0 0 0",
               request_ready, bus_valid, access_fault, bus_write, bus_byte_enable, bus_address, bus_write_data, load_data);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_loads();
    test_store_sb();
    test_faults();
    test_stray_response();
    test_stall();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
